// File: rtl/serial_word_comparator.sv
// Bit-serial magnitude comparator: consumes one (x,y) bit pair per valid cycle and reports
// G/E/L for the completed word, with runtime MSB/LSB-first order and unsigned/signed modes.
module serial_word_comparator #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_valid,
    input  logic x,
    input  logic y,
    input  logic msb_first,
    input  logic signed_mode,
    output logic busy,
    output logic done,
    output logic g_out,
    output logic e_out,
    output logic l_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {REL_EQ, REL_GT, REL_LT} rel_t;

    state_t        state_q, state_d;
    rel_t          rel_q, rel_d;
    logic [CW-1:0] count_q;
    logic          msb_first_q, signed_q;
    logic          consume, last_bit, is_sign;

    // start outranks bit_valid, so a bit presented alongside start is never consumed.
    assign consume  = (state_q == RUN) && bit_valid && !start;
    assign last_bit = (count_q == CW'(WIDTH - 1));
    assign is_sign  = msb_first_q ? (count_q == '0) : last_bit;

    // MSB-first locks on the first difference; LSB-first lets every later difference win.
    // A differing sign bit in signed mode flips the sense of the comparison.
    always_comb begin
        // NOTE: default assignment first so no path leaves rel_d unassigned (no latch).
        rel_d = rel_q;
        if ((x != y) && (!msb_first_q || rel_q == REL_EQ))
            rel_d = (x ^ (signed_q && is_sign)) ? REL_GT : REL_LT;
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start)                    state_d = RUN;
        else if (consume && last_bit) state_d = IDLE;
    end

    always_comb begin
        busy = (state_q == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            rel_q       <= REL_EQ;
            msb_first_q <= 1'b0;
            signed_q    <= 1'b0;
            done        <= 1'b0;
            g_out       <= 1'b0;
            e_out       <= 1'b1;
            l_out       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                msb_first_q <= msb_first;
                signed_q    <= signed_mode;
                count_q     <= '0;
                rel_q       <= REL_EQ;
            end else if (consume) begin
                count_q <= count_q + CW'(1);
                rel_q   <= rel_d;
                if (last_bit) begin
                    g_out <= (rel_d == REL_GT);
                    e_out <= (rel_d == REL_EQ);
                    l_out <= (rel_d == REL_LT);
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_word_comparator.sv
// Self-checking bench for serial_word_comparator: directed cases plus random words checked
// against an arithmetic reference comparison of the whole operands.
module tb_serial_word_comparator;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset, start, bit_valid, x, y, msb_first, signed_mode;
    logic busy, done, g_out, e_out, l_out;

    logic s_start, s_bv, s_x, s_y, s_msb, s_sgn;
    logic s_busy, s_done, s_g, s_e, s_l;

    int total = 0;
    int bad   = 0;
    logic exp_g = 1'b0, exp_e = 1'b1, exp_l = 1'b0;

    always #5 clk = ~clk;

    serial_word_comparator #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid), .x(x), .y(y),
        .msb_first(msb_first), .signed_mode(signed_mode), .busy(busy), .done(done),
        .g_out(g_out), .e_out(e_out), .l_out(l_out)
    );

    serial_word_comparator #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(s_start), .bit_valid(s_bv), .x(s_x), .y(s_y),
        .msb_first(s_msb), .signed_mode(s_sgn), .busy(s_busy), .done(s_done),
        .g_out(s_g), .e_out(s_e), .l_out(s_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: compare the whole operands as integers, then encode {g,e,l}.
    function automatic logic [2:0] model(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                         input logic sgn);
        longint xi, yi;
        xi = longint'(xv);
        yi = longint'(yv);
        if (sgn && xv[W-1]) xi -= (longint'(1) << W);
        if (sgn && yv[W-1]) yi -= (longint'(1) << W);
        if (xi > yi)  return 3'b100;
        if (xi == yi) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int bit_index(input logic msb, input int i);
        return msb ? (W - 1 - i) : i;
    endfunction

    task automatic begin_word(input string tag, input logic msb, input logic sgn);
        start = 1'b1; msb_first = msb; signed_mode = sgn; bit_valid = 1'b0;
        x = 1'b1; y = 1'b0;
        step();
        start = 1'b0;
        check({tag, "_start"}, {busy, done, g_out, e_out, l_out},
              {1'b1, 1'b0, exp_g, exp_e, exp_l});
    endtask

    task automatic feed_bit(input logic [W-1:0] xv, input logic [W-1:0] yv,
                            input logic msb, input int i);
        x = xv[bit_index(msb, i)];
        y = yv[bit_index(msb, i)];
        bit_valid = 1'b1;
        step();
        bit_valid = 1'b0;
    endtask

    task automatic feed_partial(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                                input logic msb, input int n);
        for (int i = 0; i < n; i++) begin
            feed_bit(xv, yv, msb, i);
            check($sformatf("%s_part%0d", tag, i), {busy, done, g_out, e_out, l_out},
                  {1'b1, 1'b0, exp_g, exp_e, exp_l});
        end
    endtask

    // stall_mode: 0 none, 1 alternate valid/idle, 2 random idle cycles.
    task automatic run_word(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                            input logic msb, input logic sgn, input int stall_mode);
        int n;
        begin_word(tag, msb, sgn);
        for (int i = 0; i < W; i++) begin
            n = (stall_mode == 1) ? ((i > 0) ? 1 : 0) :
                (stall_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int k = 0; k < n; k++) begin
                x = $urandom; y = $urandom; bit_valid = 1'b0;
                step();
                check($sformatf("%s_stall%0d", tag, i), {busy, done, g_out, e_out, l_out},
                      {1'b1, 1'b0, exp_g, exp_e, exp_l});
            end
            feed_bit(xv, yv, msb, i);
            if (i < W - 1) begin
                check($sformatf("%s_bit%0d", tag, i), {busy, done, g_out, e_out, l_out},
                      {1'b1, 1'b0, exp_g, exp_e, exp_l});
            end else begin
                {exp_g, exp_e, exp_l} = model(xv, yv, sgn);
                check({tag, "_done"}, {busy, done, g_out, e_out, l_out},
                      {1'b0, 1'b1, exp_g, exp_e, exp_l});
            end
        end
        bit_valid = 1'b1;
        x = $urandom; y = $urandom;
        step();
        bit_valid = 1'b0;
        check({tag, "_after"}, {busy, done, g_out, e_out, l_out},
              {1'b0, 1'b0, exp_g, exp_e, exp_l});
    endtask

    initial begin
        logic [W-1:0] rx, ry;
        logic         rm, rs;

        reset = 1'b0; start = 1'b0; bit_valid = 1'b0; x = 1'b0; y = 1'b0;
        msb_first = 1'b1; signed_mode = 1'b0;
        s_start = 1'b0; s_bv = 1'b0; s_x = 1'b0; s_y = 1'b0; s_msb = 1'b1; s_sgn = 1'b0;
        #12;
        check("reset_vals", {busy, done, g_out, e_out, l_out}, 5'b00010);
        @(negedge clk);
        reset = 1'b1;
        step();

        // IDLE ignores bit_valid
        bit_valid = 1'b1; x = 1'b1; y = 1'b0;
        step();
        bit_valid = 1'b0;
        check("idle_ignore", {busy, done, g_out, e_out, l_out}, 5'b00010);

        run_word("t1_umsb",   8'hA5, 8'hA3, 1'b1, 1'b0, 0);
        run_word("t2_ulsb",   8'h12, 8'h81, 1'b0, 1'b0, 0);
        run_word("t2_ulsb_b", 8'h81, 8'h12, 1'b0, 1'b0, 0);
        run_word("t3_smsb",   8'h80, 8'h7F, 1'b1, 1'b1, 0);
        run_word("t3_umsb",   8'h80, 8'h7F, 1'b1, 1'b0, 0);
        run_word("t3_slsb",   8'h80, 8'h7F, 1'b0, 1'b1, 0);

        // start coincident with the completing bit: abort, no done, outputs held (l=1)
        begin_word("coinc", 1'b0, 1'b0);
        feed_partial("coinc", 8'hFF, 8'h00, 1'b0, W - 1);
        x = 1'b1; y = 1'b0; bit_valid = 1'b1; start = 1'b1;
        step();
        start = 1'b0; bit_valid = 1'b0;
        check("coinc_abort", {busy, done, g_out, e_out, l_out},
              {1'b1, 1'b0, exp_g, exp_e, exp_l});

        run_word("t4_toggle", 8'h3C, 8'h3C, 1'b1, 1'b0, 1);

        // restart after 4 bits, then a full word
        begin_word("t5_first", 1'b1, 1'b0);
        feed_partial("t5_first", 8'hFF, 8'h00, 1'b1, 4);
        run_word("t5_second", 8'h01, 8'h00, 1'b1, 1'b0, 0);

        // reset mid-word
        run_word("t6_pre", 8'h10, 8'h20, 1'b0, 1'b0, 0);
        begin_word("t6_mid", 1'b1, 1'b0);
        feed_partial("t6_mid", 8'hF0, 8'h0F, 1'b1, 5);
        reset = 1'b0;
        #1;
        check("t6_reset", {busy, done, g_out, e_out, l_out}, 5'b00010);
        {exp_g, exp_e, exp_l} = 3'b010;
        @(negedge clk);
        reset = 1'b1;
        step();
        run_word("t6_post", 8'hF0, 8'h0F, 1'b1, 1'b1, 0);

        // random words against the reference model
        for (int n = 0; n < 30; n++) begin
            rx = $urandom; ry = ($urandom_range(0, 3) == 0) ? rx : W'($urandom);
            rm = $urandom; rs = $urandom;
            run_word($sformatf("rnd%0d", n), rx, ry, rm, rs, int'($urandom_range(0, 2)));
        end

        // WIDTH=1: the single bit is the sign bit
        s_start = 1'b1; s_sgn = 1'b1; s_msb = $urandom;
        step();
        s_start = 1'b0; s_x = 1'b1; s_y = 1'b0; s_bv = 1'b1;
        step();
        s_bv = 1'b0;
        check("w1_signed", {s_busy, s_done, s_g, s_e, s_l}, 5'b01001);
        s_start = 1'b1; s_sgn = 1'b0;
        step();
        s_start = 1'b0; s_bv = 1'b1;
        step();
        s_bv = 1'b0;
        check("w1_unsigned", {s_busy, s_done, s_g, s_e, s_l}, 5'b01100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
